// File: rtl/titan_lsu_pkg.sv
// Shared definitions for the Titan load/store unit: mem_flags bit positions,
// byte-lane select constants, access size and FSM state encodings.
package def;

    localparam int MEM_WR_BIT   = 5;
    localparam int MEM_RD_BIT   = 4;
    localparam int MEM_WORD_BIT = 3;
    localparam int MEM_HW_BIT   = 2;
    localparam int MEM_BYTE_BIT = 1;
    localparam int MEM_UNS_BIT  = 0;

    localparam logic [3:0] SEL_B0    = 4'b0001;
    localparam logic [3:0] SEL_LO_HW = 4'b0011;
    localparam logic [3:0] SEL_HI_HW = 4'b1100;
    localparam logic [3:0] SEL_ALL   = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest size bit wins if decode ever sets more than one.
    function automatic size_e decode_size(input logic [5:0] flags);
        if (flags[MEM_WORD_BIT])
            return SZ_WORD;
        else if (flags[MEM_HW_BIT])
            return SZ_HALF;
        else
            return SZ_BYTE;
    endfunction

endpackage

// File: rtl/titan_lsu_align.sv
// Combinational lane logic: store byte-lane enables / data replication and
// load byte/halfword extract with sign or zero extension.
module titan_lsu_align
    import def::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_sel,
    output logic [31:0] st_dat,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_uns,
    input  logic [31:0] ld_bus,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        st_sel = SEL_ALL;
        st_dat = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                st_sel = SEL_B0 << st_off;
                st_dat = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_sel = st_off[1] ? SEL_HI_HW : SEL_LO_HW;
                st_dat = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_v  = ld_bus[{ld_off, 3'b000} +: 8];
        half_v  = ld_off[1] ? ld_bus[31:16] : ld_bus[15:0];
        ld_data = ld_bus;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{byte_v[7] & ~ld_uns}}, byte_v};
            SZ_HALF: ld_data = {{16{half_v[15] & ~ld_uns}}, half_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/titan_lsu.sv
// Titan MEM-stage load/store unit: one bus transaction per memory op, pipeline
// stall until completion. Define TITAN_LSU_MISALIGN_TRAP_EN to trap misaligned hw/word.
module titan_lsu
    import def::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_ex_sel_i,
    input  logic [5:0]        mem_flags_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o,
    output logic              stall_o,
    output logic              fault_o,
    output logic              misaligned_o,
    output logic [ADDR_W-1:0] dport_addr_o,
    output logic [XLEN-1:0]   dport_dat_o,
    output logic [3:0]        dport_sel_o,
    output logic              dport_we_o,
    output logic              dport_cyc_o,
    output logic              dport_stb_o,
    input  logic [XLEN-1:0]   dport_dat_i,
    input  logic              dport_ack_i,
    input  logic              dport_err_i
);

    state_e      state_q, state_d;
    logic        req, req_mis, accept, bus_end;
    size_e       req_size;
    logic [1:0]  size_q, off_q;
    logic        uns_q, cyc_q;
    logic [3:0]  st_sel;
    logic [31:0] st_dat, ld_data;

    assign req = mem_ex_sel_i
               & (mem_flags_i[MEM_WR_BIT] | mem_flags_i[MEM_RD_BIT])
               & (mem_flags_i[MEM_WORD_BIT] | mem_flags_i[MEM_HW_BIT] | mem_flags_i[MEM_BYTE_BIT]);
    assign req_size = decode_size(mem_flags_i);

`ifdef TITAN_LSU_MISALIGN_TRAP_EN
    assign req_mis = ((req_size == SZ_HALF) && addr_i[0]) ||
                     ((req_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
`else
    assign req_mis = 1'b0;
`endif

    titan_lsu_align u_align (
        .st_size  (req_size),
        .st_off   (addr_i[1:0]),
        .st_wdata (wdata_i),
        .st_sel   (st_sel),
        .st_dat   (st_dat),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_uns   (uns_q),
        .ld_bus   (dport_dat_i),
        .ld_data  (ld_data)
    );

    // Stall is a function of state and request only; bus inputs never reach it.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                stall_o = 1'b1;
                accept  = ~req_mis;
                state_d = req_mis ? DONE : BUSY;
            end
            BUSY: begin
                stall_o = 1'b1;
                if (dport_ack_i || dport_err_i) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_end = (state_q == BUSY) && (dport_ack_i || dport_err_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            dport_addr_o <= '0;
            dport_dat_o  <= '0;
            dport_sel_o  <= '0;
            dport_we_o   <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
            uns_q        <= 1'b0;
            rdata_o      <= '0;
            fault_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_o <= (state_q == BUSY) && dport_err_i;
            if (accept) begin
                cyc_q        <= 1'b1;
                dport_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
                dport_dat_o  <= st_dat;
                dport_sel_o  <= st_sel;
                dport_we_o   <= mem_flags_i[MEM_WR_BIT];
                size_q       <= req_size;
                off_q        <= addr_i[1:0];
                uns_q        <= mem_flags_i[MEM_UNS_BIT];
            end
            if (bus_end) begin
                cyc_q <= 1'b0;
                if (!dport_err_i && !dport_we_o) rdata_o <= ld_data;
            end
        end
    end

    assign dport_cyc_o = cyc_q;
    assign dport_stb_o = cyc_q;

`ifdef TITAN_LSU_MISALIGN_TRAP_EN
    logic mis_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) mis_q <= 1'b0;
        else       mis_q <= (state_q == IDLE) && req && req_mis;
    end
    assign misaligned_o = mis_q;
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_titan_lsu.sv
// Directed self-checking bench for titan_lsu with a zero/N-wait bus slave.
module tb_titan_lsu;

    logic        clk_i, rst_i;
    logic        mem_ex_sel_i;
    logic [5:0]  mem_flags_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        stall_o, fault_o, misaligned_o;
    logic [31:0] dport_addr_o, dport_dat_o, dport_dat_i;
    logic [3:0]  dport_sel_o;
    logic        dport_we_o, dport_cyc_o, dport_stb_o, dport_ack_i, dport_err_i;

    localparam logic [5:0] F_SB  = 6'b100010;
    localparam logic [5:0] F_SH  = 6'b100100;
    localparam logic [5:0] F_SW  = 6'b101000;
    localparam logic [5:0] F_LB  = 6'b010010;
    localparam logic [5:0] F_LBU = 6'b010011;
    localparam logic [5:0] F_LH  = 6'b010100;
    localparam logic [5:0] F_LW  = 6'b011000;
    localparam logic [5:0] F_RW  = 6'b111000;
    localparam logic [5:0] F_NSZ = 6'b010000;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] r_sel, r_dat, r_addr, r_rdata;
    logic        r_we, r_cyc_seen, r_done, r_fault, r_mis, p_cyc, p_fault, p_mis;
    int          r_stall;

    titan_lsu dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_ex_sel_i(mem_ex_sel_i), .mem_flags_i(mem_flags_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
        .fault_o(fault_o), .misaligned_o(misaligned_o), .dport_addr_o(dport_addr_o),
        .dport_dat_o(dport_dat_o), .dport_sel_o(dport_sel_o), .dport_we_o(dport_we_o),
        .dport_cyc_o(dport_cyc_o), .dport_stb_o(dport_stb_o), .dport_dat_i(dport_dat_i),
        .dport_ack_i(dport_ack_i), .dport_err_i(dport_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request and serve it; results land in r_* (DONE cycle) and p_* (cycle after).
    task automatic run_op(input string tag, input logic [5:0] fl, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, input logic [31:0] bus,
                          input logic berr);
        int wcnt;
        wcnt = 0; r_cyc_seen = 0; r_stall = 0; r_done = 0;
        r_sel = 0; r_dat = 0; r_addr = 0; r_we = 0;
        mem_ex_sel_i = 1'b1; mem_flags_i = fl; addr_i = a; wdata_i = wd;
        #1;
        if (stall_o) r_stall++;
        for (int c = 0; c < 40 && !r_done; c++) begin
            tick();
            dport_ack_i = 1'b0; dport_err_i = 1'b0;
            if (dport_cyc_o) begin
                if (!r_cyc_seen) begin
                    r_cyc_seen = 1'b1;
                    r_sel = {28'd0, dport_sel_o}; r_dat = dport_dat_o;
                    r_addr = dport_addr_o; r_we = dport_we_o;
                end
                if (wcnt == waits) begin
                    if (berr) dport_err_i = 1'b1;
                    else begin dport_ack_i = 1'b1; dport_dat_i = bus; end
                end
                wcnt++;
            end
            #1;
            if (stall_o) r_stall++;
            else begin
                r_done = 1'b1; r_rdata = rdata_o; r_fault = fault_o; r_mis = misaligned_o;
            end
        end
        chk({tag, "_done"}, {31'd0, r_done}, 32'd1);
        tick();
        p_cyc = dport_cyc_o; p_fault = fault_o; p_mis = misaligned_o;
        mem_ex_sel_i = 1'b0; mem_flags_i = '0;
        dport_ack_i = 1'b0; dport_err_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; mem_ex_sel_i = 0; mem_flags_i = 0; addr_i = 0; wdata_i = 0;
        dport_dat_i = 0; dport_ack_i = 0; dport_err_i = 0;
        tick(); tick();
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_cyc", {31'd0, dport_cyc_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_addr", dport_addr_o, 32'd0);
        chk("rst_sel", {28'd0, dport_sel_o}, 32'd0);
        chk("rst_flags", {30'd0, fault_o, misaligned_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        run_op("sb", F_SB, 32'h1003, 32'h000000AB, 0, 32'h0, 1'b0);
        chk("sb_sel", r_sel, 32'h8);
        chk("sb_dat", r_dat, 32'hABABABAB);
        chk("sb_we", {31'd0, r_we}, 32'd1);
        chk("sb_addr", r_addr, 32'h1000);
        chk("sb_stall", r_stall, 32'd2);
        chk("sb_rdata", r_rdata, 32'd0);

        run_op("lb", F_LB, 32'h2001, 32'h0, 0, 32'h00008000, 1'b0);
        chk("lb_rdata", r_rdata, 32'hFFFFFF80);
        chk("lb_we", {31'd0, r_we}, 32'd0);
        run_op("lbu", F_LBU, 32'h2001, 32'h0, 0, 32'h00008000, 1'b0);
        chk("lbu_rdata", r_rdata, 32'h00000080);

        run_op("lh", F_LH, 32'h2002, 32'h0, 3, 32'h92340000, 1'b0);
        chk("lh_rdata", r_rdata, 32'hFFFF9234);
        chk("lh_stall", r_stall, 32'd5);

        run_op("lwerr", F_LW, 32'h4000, 32'h0, 0, 32'h11111111, 1'b1);
        chk("err_fault", {31'd0, r_fault}, 32'd1);
        chk("err_rdata", r_rdata, 32'hFFFF9234);
        chk("err_fault_pulse", {31'd0, p_fault}, 32'd0);

        run_op("sh", F_SH, 32'h7002, 32'h0000BEEF, 1, 32'h0, 1'b0);
        chk("sh_sel", r_sel, 32'hC);
        chk("sh_dat", r_dat, 32'hBEEFBEEF);
        chk("sh_stall", r_stall, 32'd3);

        run_op("rw", F_RW, 32'h6000, 32'h11223344, 0, 32'h77777777, 1'b0);
        chk("rw_we", {31'd0, r_we}, 32'd1);
        chk("rw_sel", r_sel, 32'hF);
        chk("rw_dat", r_dat, 32'h11223344);
        chk("rw_rdata", r_rdata, 32'hFFFF9234);

        mem_ex_sel_i = 1'b1; mem_flags_i = F_NSZ; addr_i = 32'h8000;
        #1;
        chk("nsz_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("nsz_cyc", {31'd0, dport_cyc_o}, 32'd0);
        mem_ex_sel_i = 1'b0; mem_flags_i = '0;
        tick();

        run_op("mis", F_LW, 32'h3002, 32'h0, 0, 32'hCAFEF00D, 1'b0);
`ifdef TITAN_LSU_MISALIGN_TRAP_EN
        chk("mis_cyc", {31'd0, r_cyc_seen}, 32'd0);
        chk("mis_flag", {31'd0, r_mis}, 32'd1);
        chk("mis_pulse", {31'd0, p_mis}, 32'd0);
        chk("mis_stall", r_stall, 32'd1);
        chk("mis_rdata", r_rdata, 32'hFFFF9234);
`else
        chk("mis_sel", r_sel, 32'hF);
        chk("mis_addr", r_addr, 32'h3000);
        chk("mis_flag", {31'd0, r_mis}, 32'd0);
        chk("mis_rdata", r_rdata, 32'hCAFEF00D);
`endif

        mem_ex_sel_i = 1'b1; mem_flags_i = F_LW; addr_i = 32'h4010;
        #1;
        chk("rb_stall", {31'd0, stall_o}, 32'd1);
        tick();
        chk("rb_busy_cyc", {31'd0, dport_cyc_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; mem_ex_sel_i = 1'b0; mem_flags_i = '0;
        chk("rb_cyc", {30'd0, dport_cyc_o, dport_stb_o}, 32'd0);
        dport_ack_i = 1'b1; dport_dat_i = 32'h55555555;
        #1;
        chk("rb_stall_idle", {31'd0, stall_o}, 32'd0);
        tick();
        dport_ack_i = 1'b0;
        chk("rb_late_cyc", {31'd0, dport_cyc_o}, 32'd0);
        chk("rb_late_rdata", rdata_o, 32'd0);
        chk("rb_late_stall", {31'd0, stall_o}, 32'd0);

        run_op("b2b_sw", F_SW, 32'h5004, 32'h12345678, 0, 32'h0, 1'b0);
        chk("b2b_sw_addr", r_addr, 32'h5004);
        chk("b2b_noreissue", {31'd0, p_cyc}, 32'd0);
        run_op("b2b_lw", F_LW, 32'h5008, 32'h0, 0, 32'h0BADBEEF, 1'b0);
        chk("b2b_lw_addr", r_addr, 32'h5008);
        chk("b2b_lw_we", {31'd0, r_we}, 32'd0);
        chk("b2b_lw_stall", r_stall, 32'd2);
        chk("b2b_lw_rdata", r_rdata, 32'h0BADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
